// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-back controller for the 32x32 register file.
// After reset it zero-fills x1..x31, then shares the single write port
// between the ALU result path (requester 0) and the load-return path
// (requester 1) with a valid/ready handshake. Write-port outputs are registered.
// Optional feature macro: RF_WB_ARB_RR_EN selects round-robin arbitration;
// when undefined, requester 1 (load) has fixed priority.
module reg_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        reg_we,
    output logic [4:0]  wr_rd,
    output logic [31:0] wr_data,
    output logic        init_done
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic        reg_we_q;
    logic [4:0]  wr_rd_q;
    logic [31:0] wr_data_q;
    logic        init_done_q;

    logic        active;
    logic        gnt0;
    logic        gnt1;
    logic        fire;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

`ifdef RF_WB_ARB_RR_EN
    // Index of the most recently granted requester; 1 out of reset so the
    // first contested grant goes to requester 0.
    logic        last_q;
    logic        last_d;
`endif

    // Grant selection and write-port mux; readies are held low during INIT
    // and while rst is asserted so no request is acknowledged and then lost.
    always_comb begin
        active = (state_q == RUN) && !rst;
`ifdef RF_WB_ARB_RR_EN
        gnt0   = active && req0_valid && (!req1_valid || last_q);
        gnt1   = active && req1_valid && (!req0_valid || !last_q);
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
`else
        gnt0   = active && req0_valid && !req1_valid;
        gnt1   = active && req1_valid;
`endif
        fire     = gnt0 || gnt1;
        sel_rd   = gnt1 ? req1_rd   : req0_rd;
        sel_data = gnt1 ? req1_data : req0_data;
        cnt_d    = cnt_q + 5'd1;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Zero-fill / run FSM with registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= 5'd1;
            reg_we_q    <= 1'b0;
            wr_rd_q     <= 5'd0;
            wr_data_q   <= 32'd0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    reg_we_q  <= 1'b1;
                    wr_rd_q   <= cnt_q;
                    wr_data_q <= 32'd0;
                    cnt_q     <= cnt_d;
                    if (cnt_q == 5'd31) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (fire) begin
                        // A write to x0 completes the handshake but never
                        // reaches the register file.
                        reg_we_q  <= (sel_rd != 5'd0);
                        wr_rd_q   <= sel_rd;
                        wr_data_q <= sel_data;
                    end else begin
                        reg_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

`ifdef RF_WB_ARB_RR_EN
    // Round-robin pointer follows every accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign reg_we    = reg_we_q;
    assign wr_rd     = wr_rd_q;
    assign wr_data   = wr_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter (both arbitration builds).
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        reg_we;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    reg_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .reg_we     (reg_we),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-fill sequence check with readies required low before each edge.
    task automatic check_fill(input string tag);
        for (int i = 1; i <= 31; i++) begin
            check({tag, "_rdy0"}, {31'd0, req0_ready}, 32'd0);
            check({tag, "_rdy1"}, {31'd0, req1_ready}, 32'd0);
            step();
            check({tag, "_we"},   {31'd0, reg_we}, 32'd1);
            check({tag, "_rd"},   {27'd0, wr_rd}, i);
            check({tag, "_data"}, wr_data, 32'd0);
            check({tag, "_done"}, {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
        end
    endtask

    logic [3:0]  exp_gnt;   // bit k = requester expected in contested cycle k
    logic        first_win;
    logic [31:0] final_data;

    initial begin
`ifdef RF_WB_ARB_RR_EN
        exp_gnt    = 4'b1010;
        first_win  = 1'b0;
        final_data = 32'hB;
`else
        exp_gnt    = 4'b1111;
        first_win  = 1'b1;
        final_data = 32'hA;
`endif
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_rd    = 5'd9;
        req0_data  = 32'h99;
        req1_valid = 1'b1;
        req1_rd    = 5'd10;
        req1_data  = 32'hAA;
        step();
        step();
        check("rst_we",   {31'd0, reg_we}, 32'd0);
        check("rst_rd",   {27'd0, wr_rd}, 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_done", {31'd0, init_done}, 32'd0);

        // Zero-fill with both valids held high.
        rst = 1'b0;
        check_fill("fill");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check("idle_we", {31'd0, reg_we}, 32'd0);
        check("idle_rd_hold", {27'd0, wr_rd}, 32'd31);
        check("done_hold", {31'd0, init_done}, 32'd1);

        // Lone ALU write.
        req0_valid = 1'b1;
        req0_rd    = 5'd5;
        req0_data  = 32'hDEADBEEF;
        #1;
        check("alu_rdy0", {31'd0, req0_ready}, 32'd1);
        check("alu_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        check("alu_we",   {31'd0, reg_we}, 32'd1);
        check("alu_rd",   {27'd0, wr_rd}, 32'd5);
        check("alu_data", wr_data, 32'hDEADBEEF);
        step();
        check("alu_idle_we", {31'd0, reg_we}, 32'd0);
        check("alu_idle_data", wr_data, 32'hDEADBEEF);

        // Load write to x0: accepted, no write enable.
        req1_valid = 1'b1;
        req1_rd    = 5'd0;
        req1_data  = 32'h1234;
        #1;
        check("x0_rdy1", {31'd0, req1_ready}, 32'd1);
        check("x0_rdy0", {31'd0, req0_ready}, 32'd0);
        step();
        req1_valid = 1'b0;
        check("x0_we",   {31'd0, reg_we}, 32'd0);
        check("x0_data", wr_data, 32'h1234);

        // Four contested cycles; the accepted requester re-presents at once.
        req0_valid = 1'b1;
        req0_rd    = 5'd3;
        req0_data  = 32'h33;
        req1_valid = 1'b1;
        req1_rd    = 5'd4;
        req1_data  = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("ctst_rdy0", {31'd0, req0_ready}, {31'd0, ~exp_gnt[k]});
            check("ctst_rdy1", {31'd0, req1_ready}, {31'd0, exp_gnt[k]});
            step();
            check("ctst_we", {31'd0, reg_we}, 32'd1);
            check("ctst_rd", {27'd0, wr_rd}, exp_gnt[k] ? 32'd4 : 32'd3);
            check("ctst_data", wr_data, exp_gnt[k] ? 32'h44 : 32'h33);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Same destination contest: loser writes second and wins the register.
        req0_valid = 1'b1;
        req0_rd    = 5'd7;
        req0_data  = 32'hA;
        req1_valid = 1'b1;
        req1_rd    = 5'd7;
        req1_data  = 32'hB;
        #1;
        check("same_rdy1", {31'd0, req1_ready}, {31'd0, first_win});
        step();
        check("same1_rd", {27'd0, wr_rd}, 32'd7);
        check("same1_data", wr_data, first_win ? 32'hB : 32'hA);
        if (first_win) req1_valid = 1'b0;
        else           req0_valid = 1'b0;
        #1;
        check("same2_rdy", {31'd0, req0_ready | req1_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("same2_we", {31'd0, reg_we}, 32'd1);
        check("same2_rd", {27'd0, wr_rd}, 32'd7);
        check("same2_final", wr_data, final_data);

        // Reset mid-run with an unaccepted ALU request pending.
        req0_valid = 1'b1;
        req0_rd    = 5'd12;
        req0_data  = 32'hC0FFEE;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        check("rrst_we",   {31'd0, reg_we}, 32'd0);
        check("rrst_rd",   {27'd0, wr_rd}, 32'd0);
        check("rrst_data", wr_data, 32'd0);
        check("rrst_done", {31'd0, init_done}, 32'd0);
        check_fill("refill");
        check("repost_rdy0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        check("repost_we",   {31'd0, reg_we}, 32'd1);
        check("repost_rd",   {27'd0, wr_rd}, 32'd12);
        check("repost_data", wr_data, 32'hC0FFEE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
